// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multi-cycle fetch/decode/execute controller for the 16-bit datapath
module cpu_control_fsm #(
    parameter int DATA_W   = 16,
    parameter int SEL_W    = 5,
    parameter int ALU_OP_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_W-1:0]   instr,
    input  logic                mem_ready,
    output logic                mem_rd,
    output logic                mem_we,
    output logic                addr_sel,
    output logic [DATA_W-1:0]   immediate,
    output logic [15:0]         enable,
    output logic [ALU_OP_W-1:0] opcode,
    output logic [SEL_W-1:0]    control1,
    output logic [SEL_W-1:0]    control2,
    output logic                imm_control,
    output logic                buff_en,
    output logic                en_pc,
    output logic                pc_mux_en,
    output logic                halted,
    output logic                illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_BR    = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [3:0] EXT_LOAD = 4'h0;
    localparam logic [3:0] EXT_STOR = 4'h4;

    state_t            state, state_next;
    logic [DATA_W-1:0] ir;

    logic [3:0]        op, rdst, ext, rsrc;
    logic [DATA_W-1:0] sext8;
    logic [15:0]       rdst_onehot;
    logic              legal;

    // Same code set serves as R-type ext field and immediate-form opcode.
    function automatic logic is_alu_code(input logic [3:0] v);
        return (v == 4'h5) || (v == 4'h9) || (v == 4'h1) ||
               (v == 4'h2) || (v == 4'h3) || (v == 4'hD);
    endfunction

    assign op          = ir[15:12];
    assign rdst        = ir[11:8];
    assign ext         = ir[7:4];
    assign rsrc        = ir[3:0];
    assign sext8       = {{(DATA_W-8){ir[7]}}, ir[7:0]};
    assign rdst_onehot = 16'h0001 << rdst;

    assign legal = ((op == OP_RTYPE) && is_alu_code(ext)) ||
                   is_alu_code(op) ||
                   (op == OP_BR) ||
                   ((op == OP_MEM) && ((ext == EXT_LOAD) || (ext == EXT_STOR))) ||
                   (op == OP_HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= state_next;
            if ((state == S_FETCH) && mem_ready)
                ir <= instr;
        end
    end

    always_comb begin
        state_next  = state;
        mem_rd      = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        immediate   = '0;
        enable      = '0;
        opcode      = '0;
        control1    = '0;
        control2    = '0;
        imm_control = 1'b0;
        buff_en     = 1'b0;
        en_pc       = 1'b0;
        pc_mux_en   = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start)
                    state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                // PC advances for every instruction, so branches are relative to PC+1.
                en_pc = 1'b1;
                if (op == OP_HALT)
                    state_next = S_HALT;
                else if (!legal) begin
                    illegal    = 1'b1;
                    state_next = S_FETCH;
                end else if (op == OP_MEM)
                    state_next = S_MEM;
                else
                    state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH;
                if (op == OP_BR) begin
                    en_pc     = 1'b1;
                    pc_mux_en = 1'b1;
                    immediate = sext8;
                end else if (op == OP_RTYPE) begin
                    opcode   = {{(ALU_OP_W-4){1'b0}}, ext};
                    control1 = {{(SEL_W-4){1'b0}}, rdst};
                    control2 = {{(SEL_W-4){1'b0}}, rsrc};
                    buff_en  = 1'b1;
                    enable   = rdst_onehot;
                end else begin
                    opcode      = {{(ALU_OP_W-4){1'b0}}, op};
                    control1    = {{(SEL_W-4){1'b0}}, rdst};
                    imm_control = 1'b1;
                    immediate   = sext8;
                    buff_en     = 1'b1;
                    enable      = rdst_onehot;
                end
            end
            S_MEM: begin
                addr_sel = 1'b1;
                if (ext == EXT_STOR) begin
                    mem_we   = 1'b1;
                    control1 = {{(SEL_W-4){1'b0}}, rdst};
                    control2 = {{(SEL_W-4){1'b0}}, rsrc};
                end else begin
                    // Load data only reaches the bus in the completing cycle.
                    mem_rd   = 1'b1;
                    control1 = {{(SEL_W-4){1'b0}}, rsrc};
                    if (mem_ready)
                        enable = rdst_onehot;
                end
                if (mem_ready)
                    state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
